load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store front end between the EX/MEM pipeline register and the byte-addressed, big-endian word data memory (32-bit read/write ports, 256 bytes, one-cycle registered read). It accepts one request at a time over a valid/ready handshake. It checks alignment and range, and performs byte and halfword stores as read-modify-write, because the memory only writes whole words. Load results are extracted and sign- or zero-extended, then returned over a valid/ready response channel.

## Interface
- MEM_BYTES, 256, data memory size in bytes; an address at or above it is an error.
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  equals (state == IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is reserved and returns an error.
- req_signed  in  1  sign-extend a sub-word load; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range or reserved size.
- mem_addr  out  32  word-aligned address {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  full word to write.
- mem_read  out  1  memory read strobe, one cycle.
- mem_write  out  1  memory write strobe, one cycle.
- mem_rdata  in  32  memory read data, valid the cycle after mem_read.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- A request is accepted on any posedge with req_valid && req_ready. All request fields are latched at acceptance.
- Error if any of: size 01 with addr[0] = 1; size 10 with addr[1:0] ≠ 0; size 11; addr + bytes > MEM_BYTES.
  - Path: IDLE → RESP with resp_err = 1.
  - No mem_read or mem_write pulse is issued.
- Load: IDLE → RD (mem_read = 1) → CAP (register the extracted mem_rdata) → RESP.
- Word store: IDLE → WR (mem_write = 1, mem_wdata = req_wdata) → RESP.
- Byte or half store: IDLE → RD → CAP (merge) → WR → RESP.
- Lane rules (big-endian), with off = addr[1:0]:
  - Byte lane is bits [31-8*off -: 8].
  - Half at off 0 is bits [31:16]; half at off 2 is bits [15:0].
  - Merge replaces only the target lane of the captured word with the low bits of req_wdata.
- Load extension: replicate the lane MSB when req_signed = 1, else zero-fill. A word load is passed through unchanged.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_ready = 1, then the block goes to IDLE.
- A new request can only be accepted in IDLE, so a simultaneous response handshake and new request cannot occur.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from req_* or resp_ready to any output.
- Latency, counted from the acceptance edge to the first cycle with resp_valid high:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- mem_read and mem_write are never high in the same cycle. Each is high for exactly one cycle per access.
- mem_addr and mem_wdata are stable for the whole time a strobe is high.
- Reset values: state IDLE (so req_ready = 1); resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Reset asserted mid-transaction:
  - It clears the outputs immediately and discards the transaction; no response is produced.
  - In a read-modify-write, a write has not been issued unless WR was already entered. The memory word may then hold the old or the merged value; the bench must accept either.

## Structure
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the lsu_state_t enum;
  - the default MEM_BYTES.
- One combinational sub-module, mem_lane_align, performs load extraction/extension and store merge from (word, off, size, signed, wdata).

## Test plan
- sw 0x12345678 to 0x14, then lw from 0x14 → resp_rdata 0x12345678, memory bytes 20..23 hold 12,34,56,78, resp_err 0.
- sb 0xF0 to 0x16, then lw from 0x14 → 0x1234F078. lb from 0x16 → 0xFFFFFFF0. lbu from 0x16 → 0x000000F0.
- sh 0xBEEF to 0x16 → lw from 0x14 returns 0x1234BEEF. lh from 0x16 → 0xFFFFBEEF. lhu from 0x14 → 0x00001234.
- lw from 0x15, sh to 0x13, lw from 0x100, size 11 → each gives resp_err 1 one cycle after acceptance, with no mem_read or mem_write pulse.
- resp_ready held low for 3 cycles during a load → resp_valid and resp_rdata held stable and req_ready 0. The next request is accepted on the edge after the response handshake.
- rst_n pulsed low while in WR of a sh → all outputs are 0 immediately and no response is produced. After release, a following lw from 0x14 completes with resp_err 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mips_mem_pkg
//  Purpose   : Shared definitions for the load/store front end: access-size
//              encodings, the LSU state type and the default data memory size.
//  Revision  : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  // Default data memory size in bytes; addresses at or above it are errors.
  localparam int unsigned MEM_BYTES_DEFAULT = 256;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module    : mem_lane_align
//  Purpose   : Purely combinational big-endian lane logic. Extracts and
//              sign/zero-extends a byte/half/word from a memory word for
//              loads, and merges right-justified store data into the target
//              lane of a memory word for read-modify-write stores.
//  Ports     : word        in  32  memory word (big-endian)
//              off         in   2  byte offset within the word
//              size        in   2  access size (SZ_*)
//              sgn         in   1  sign-extend sub-word loads
//              wdata       in  32  right-justified store data
//              load_data   out 32  extracted/extended load result
//              merged_data out 32  word with the target lane replaced
//  Revision  : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Big-endian: offset 0 is the most significant byte of the word.
    case (off)
      2'd0:    byte_lane = word[31:24];
      2'd1:    byte_lane = word[23:16];
      2'd2:    byte_lane = word[15:8];
      default: byte_lane = word[7:0];
    endcase
    half_lane = off[1] ? word[15:0] : word[31:16];

    load_data   = word;
    merged_data = word;

    case (size)
      SZ_BYTE: begin
        load_data = {{24{sgn & byte_lane[7]}}, byte_lane};
        case (off)
          2'd0:    merged_data[31:24] = wdata[7:0];
          2'd1:    merged_data[23:16] = wdata[7:0];
          2'd2:    merged_data[15:8]  = wdata[7:0];
          default: merged_data[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{sgn & half_lane[15]}}, half_lane};
        if (off[1]) merged_data[15:0]  = wdata[15:0];
        else        merged_data[31:16] = wdata[15:0];
      end
      SZ_WORD: merged_data = wdata;
      default: ;
    endcase
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module    : load_store_unit
//  Purpose   : Multi-cycle load/store front end between the EX/MEM register
//              and a word-wide big-endian data memory with a one-cycle
//              registered read. One request at a time; alignment/range
//              checking; sub-word stores done as read-modify-write.
//  Ports     : clk, rst_n               clock, async active-low reset
//              req_valid/req_ready      request handshake
//              req_write/size/signed    request type
//              req_addr/req_wdata       byte address, right-justified data
//              resp_valid/resp_ready    response handshake
//              resp_rdata/resp_err      load result, error flag
//              mem_addr/mem_wdata       word address and write word
//              mem_read/mem_write       one-cycle memory strobes
//              mem_rdata                read data, valid cycle after mem_read
//  Revision  : 1.0 - initial release
// ============================================================================
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_data;

  // Request checking. The end address is one bit wider than the address so
  // that a request near 2^32 cannot wrap and slip under the range limit.
  always_comb begin
    case (req_size)
      SZ_BYTE: req_bytes = 3'd1;
      SZ_HALF: req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_end = {1'b0, req_addr} + {30'd0, req_bytes};
    req_err = (req_size == SZ_RSVD)
           || ((req_size == SZ_HALF) && req_addr[0])
           || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
           || (req_end > 33'(MEM_BYTES));
  end

  // Lane logic operates on the word returned by the read issued in RD; it is
  // only consumed in CAP, when mem_rdata is valid.
  mem_lane_align u_align (
    .word        (mem_rdata),
    .off         (off_q),
    .size        (size_q),
    .sgn         (signed_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          size_d       = req_size;
          signed_d     = req_signed;
          off_d        = req_addr[1:0];
          wdata_d      = req_wdata;
          mem_addr_d   = {req_addr[31:2], 2'b00};
          resp_rdata_d = 32'd0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            mem_wdata_d = req_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (write_q) begin
          mem_wdata_d = merged_data;
          state_d     = WR;
        end else begin
          resp_rdata_d = load_data;
          state_d      = RESP;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module    : tb_load_store_unit
//  Purpose   : Self-checking bench for load_store_unit: directed vector table,
//              response back-pressure, mid-transaction reset, and random
//              requests checked against a byte-array reference model.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: big-endian bytes, whole-word writes, one-cycle registered read.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < 4; k++) mem[{mem_addr[7:2], 2'(k)}] <= mem_wdata[31-8*k -: 8];
    if (mem_read)
      mem_rdata <= {mem[{mem_addr[7:2], 2'd0}], mem[{mem_addr[7:2], 2'd1}],
                    mem[{mem_addr[7:2], 2'd2}], mem[{mem_addr[7:2], 2'd3}]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, bytes taken MSB-first.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int lat,
                                output int nrd, output int nwr);
    int nb;
    logic [63:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
       || (({32'd0, addr} + 64'(nb)) > 64'd256);
    rd  = 32'd0;
    nrd = 0;
    nwr = 0;
    if (er) begin
      lat = 1;
    end else if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr[7:0]) + i] = wd[8*(nb-1-i) +: 8];
      lat = (nb == 4) ? 2 : 4;
      nrd = (nb == 4) ? 0 : 1;
      nwr = 1;
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 64'(ref_mem[int'(addr[7:0]) + i]);
      if (sg && nb < 4 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
      rd  = v[31:0];
      lat = 3;
      nrd = 1;
    end
  endfunction

  // Issues one request (called at a negedge, returns at a negedge) and checks
  // latency, strobe counts, response data/error and back-pressure hold.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input int exp_nrd, input int exp_nwr, input int stall);
    int lat, nrd, nwr, nboth;
    bit got;
    logic [31:0] held_rd;
    logic        held_err;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; nboth = 0; got = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) nboth++;
      if (resp_valid) begin
        lat = c;
        got = 1;
        break;
      end
    end
    check({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
    if (!got) return;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    check({tag, "_n_read"}, 32'(nrd), 32'(exp_nrd));
    check({tag, "_n_write"}, 32'(nwr), 32'(exp_nwr));
    check({tag, "_rd_wr_overlap"}, 32'(nboth), 32'd0);
    held_rd  = resp_rdata;
    held_err = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, held_rd);
      check({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, held_err});
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, "_ready_after_hs"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_valid_after_hs"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] m_rd;
    logic        m_er;
    int          m_lat, m_nrd, m_nwr, nresp, nbad;
    logic [31:0] w;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wd;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    vecs[0]  = '{"sw_14",    1, 2'd2, 0, 32'h14,  32'h12345678, 32'h00000000, 0, 2};
    vecs[1]  = '{"lw_14",    0, 2'd2, 0, 32'h14,  32'h0,        32'h12345678, 0, 3};
    vecs[2]  = '{"sb_16",    1, 2'd0, 0, 32'h16,  32'hAAAAAAF0, 32'h00000000, 0, 4};
    vecs[3]  = '{"lw_14b",   0, 2'd2, 0, 32'h14,  32'h0,        32'h1234F078, 0, 3};
    vecs[4]  = '{"lb_16",    0, 2'd0, 1, 32'h16,  32'h0,        32'hFFFFFFF0, 0, 3};
    vecs[5]  = '{"lbu_16",   0, 2'd0, 0, 32'h16,  32'h0,        32'h000000F0, 0, 3};
    vecs[6]  = '{"sh_16",    1, 2'd1, 1, 32'h16,  32'h5555BEEF, 32'h00000000, 0, 4};
    vecs[7]  = '{"lw_14c",   0, 2'd2, 0, 32'h14,  32'h0,        32'h1234BEEF, 0, 3};
    vecs[8]  = '{"lh_16",    0, 2'd1, 1, 32'h16,  32'h0,        32'hFFFFBEEF, 0, 3};
    vecs[9]  = '{"lhu_14",   0, 2'd1, 0, 32'h14,  32'h0,        32'h00001234, 0, 3};
    vecs[10] = '{"lw_15",    0, 2'd2, 0, 32'h15,  32'h0,        32'h00000000, 1, 1};
    vecs[11] = '{"sh_13",    1, 2'd1, 0, 32'h13,  32'h0000BEEF, 32'h00000000, 1, 1};
    vecs[12] = '{"lw_100",   0, 2'd2, 0, 32'h100, 32'h0,        32'h00000000, 1, 1};
    vecs[13] = '{"sz11_14",  0, 2'd3, 0, 32'h14,  32'h0,        32'h00000000, 1, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      model(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd,
            m_rd, m_er, m_lat, m_nrd, m_nwr);
      run_req(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, m_nrd, m_nwr, 0);
      if (i == 0) begin
        w = {mem[20], mem[21], mem[22], mem[23]};
        check("sw_14_mem_bytes", w, 32'h12345678);
      end
    end

    // Back-pressure on a load response.
    model(0, 2'd2, 0, 32'h14, 32'h0, m_rd, m_er, m_lat, m_nrd, m_nwr);
    run_req("lw_stall", 0, 2'd2, 0, 32'h14, 32'h0, 32'h1234BEEF, 0, 3, 1, 0, 3);

    // Reset while a half store sits in WR.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nresp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_write) break;
    end
    check("rst_reached_wr", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    check("rst_no_resp", 32'(nresp), 32'd0);
    w = {mem[20], mem[21], mem[22], mem[23]};
    check("rst_word_old_or_new", {31'd0, (w == 32'h1234BEEF) || (w == 32'h1234CAFE)}, 32'd1);
    ref_mem[22] = mem[22];
    ref_mem[23] = mem[23];
    model(0, 2'd2, 0, 32'h14, 32'h0, m_rd, m_er, m_lat, m_nrd, m_nwr);
    run_req("lw_after_rst", 0, 2'd2, 0, 32'h14, 32'h0, m_rd, m_er, m_lat, m_nrd, m_nwr, 0);

    // Random requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 259));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'd0;
      end
      model(wr, sz, sg, addr, wd, m_rd, m_er, m_lat, m_nrd, m_nwr);
      run_req("rand", wr, sz, sg, addr, wd, m_rd, m_er, m_lat, m_nrd, m_nwr,
              int'($urandom_range(0, 2)));
    end

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("final_mem_image", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
